// File: rtl/accum_seq_pkg.sv
// Shared types and constants for the accumulate/scale sequencer.
package accum_seq_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_COUNT_W = 8;
  localparam int SHIFT_W     = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    SCALE = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_CLEAR = 2'd1,
    OP_ADD   = 2'd2,
    OP_SHL   = 2'd3
  } dp_op_t;

endpackage

// File: rtl/accum_step_dp.sv
// Result register with add-index and shift-left steps; owns the sticky
// overflow flag for the current job.
module accum_step_dp
  import accum_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  dp_op_t             op,
  input  logic [COUNT_W-1:0] addend,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  logic [WIDTH:0] addend_ext;
  logic [WIDTH:0] sum;

  // Zero-extend the index and form a WIDTH+1 bit sum so the carry is visible.
  always_comb begin
    addend_ext                = '0;
    addend_ext[COUNT_W-1:0]   = addend;
    sum                       = {1'b0, result} + addend_ext;
  end

  // Apply the selected operation; overflow only ever sets until cleared.
  always_ff @(posedge clock) begin
    if (!reset) begin
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (op)
        OP_CLEAR: begin
          result   <= '0;
          overflow <= 1'b0;
        end
        OP_ADD: begin
          result   <= sum[WIDTH-1:0];
          overflow <= overflow | sum[WIDTH];
        end
        OP_SHL: begin
          result   <= result << 1;
          overflow <= overflow | result[WIDTH-1];
        end
        default: begin
          result   <= result;
          overflow <= overflow;
        end
      endcase
    end
  end

endmodule

// File: rtl/accum_sequencer.sv
// Start/busy/done sequencer: N index accumulations followed by S doublings,
// with abort and a sticky overflow flag.
module accum_sequencer
  import accum_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int COUNT_W = DEF_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [COUNT_W-1:0] max_value,
  input  logic [SHIFT_W-1:0] shift_count,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result,
  output logic               overflow
);

  state_t             state;
  state_t             next_state;
  dp_op_t             op;
  logic [COUNT_W-1:0] index;
  logic [COUNT_W-1:0] n_latched;
  logic [COUNT_W-1:0] last_index;
  logic [SHIFT_W-1:0] s_latched;
  logic [SHIFT_W-1:0] shift_left;

  assign last_index = n_latched - COUNT_W'(1);

  // State register.
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and datapath operation select; abort suppresses the step.
  always_comb begin
    next_state = state;
    op         = OP_HOLD;
    case (state)
      IDLE: begin
        if (start) begin
          op = OP_CLEAR;
          if (max_value != '0)        next_state = ACCUM;
          else if (shift_count != '0) next_state = SCALE;
          else                        next_state = DONE;
        end
      end
      ACCUM: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          op = OP_ADD;
          if (index == last_index)
            next_state = (s_latched != '0) ? SCALE : DONE;
        end
      end
      SCALE: begin
        if (abort) begin
          next_state = IDLE;
        end else begin
          op = OP_SHL;
          if (shift_left == SHIFT_W'(1)) next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Job parameter latches plus the running index and remaining-shift counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      index      <= '0;
      n_latched  <= '0;
      s_latched  <= '0;
      shift_left <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            index      <= '0;
            n_latched  <= max_value;
            s_latched  <= shift_count;
            shift_left <= shift_count;
          end
        end
        ACCUM: if (!abort) index      <= index + COUNT_W'(1);
        SCALE: if (!abort) shift_left <= shift_left - SHIFT_W'(1);
        default: ;
      endcase
    end
  end

  assign busy = (state == ACCUM) || (state == SCALE);
  assign done = (state == DONE);

  accum_step_dp #(
    .WIDTH   (WIDTH),
    .COUNT_W (COUNT_W)
  ) u_dp (
    .clock    (clock),
    .reset    (reset),
    .op       (op),
    .addend   (index),
    .result   (result),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_accum_sequencer.sv
// Directed self-checking bench for accum_sequencer.
module tb_accum_sequencer;

  logic        clock;
  logic        reset;
  logic        start;
  logic        abort;
  logic [7:0]  max_value;
  logic [3:0]  shift_count;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        overflow;

  int errCount   = 0;
  int checkCount = 0;

  accum_sequencer #(
    .WIDTH   (16),
    .COUNT_W (8)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .abort       (abort),
    .max_value   (max_value),
    .shift_count (shift_count),
    .busy        (busy),
    .done        (done),
    .result      (result),
    .overflow    (overflow)
  );

  // Free-running 10 ns clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic ab,
                               input logic [7:0] mv, input logic [3:0] sc);
    start       = st;
    abort       = ab;
    max_value   = mv;
    shift_count = sc;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) else begin
      errCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Sample until done is seen, counting edges and busy cycles; bounded.
  task automatic waitDone(output int edges, output int busyCnt, output bit seen);
    edges   = 0;
    busyCnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busyCnt++;
      step();
      edges++;
    end
  endtask

  task automatic runJob(input string tag, input logic [7:0] n, input logic [3:0] s,
                        input int expEdges, input logic [15:0] expResult,
                        input logic expOv);
    int edges;
    int busyCnt;
    bit seen;
    applyStimulus(1'b1, 1'b0, n, s);
    step();
    applyStimulus(1'b0, 1'b0, n, s);
    waitDone(edges, busyCnt, seen);
    checkOutput({tag, "_done_seen"}, 32'(seen), 32'd1);
    checkOutput({tag, "_latency"}, 32'(edges), 32'(expEdges));
    checkOutput({tag, "_busy_cycles"}, 32'(busyCnt), 32'(expEdges));
    checkOutput({tag, "_result"}, 32'(result), 32'(expResult));
    checkOutput({tag, "_overflow"}, 32'(overflow), 32'(expOv));
    step();
    checkOutput({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_result_hold"}, 32'(result), 32'(expResult));
  endtask

  initial begin
    int edges;
    int busyCnt;
    bit seen;

    // Reset held with start asserted.
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 8'd5, 4'd0);
    step(); step(); step();
    checkOutput("rst_result", 32'(result), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'd5, 4'd0);
    reset = 1'b1;
    step();
    checkOutput("post_rst_busy", 32'(busy), 32'd0);
    step();
    checkOutput("post_rst_idle", 32'(busy), 32'd0);
    checkOutput("post_rst_result", 32'(result), 32'd0);

    // Main jobs: sum 0..N-1 then doubled S times.
    runJob("n5s0",   8'd5,   4'd0, 5,   16'd10,   1'b0);
    runJob("n255s1", 8'd255, 4'd1, 256, 16'hFD02, 1'b0);
    runJob("n255s2", 8'd255, 4'd2, 257, 16'hFA04, 1'b1);
    runJob("n0s0",   8'd0,   4'd0, 0,   16'd0,    1'b0);
    runJob("n0s3",   8'd0,   4'd3, 3,   16'd0,    1'b0);

    // Abort in the fourth ACCUM cycle.
    applyStimulus(1'b1, 1'b0, 8'd10, 4'd0);
    step();
    applyStimulus(1'b0, 1'b0, 8'd10, 4'd0);
    step(); step(); step();
    checkOutput("abort_pre_result", 32'(result), 32'd3);
    checkOutput("abort_pre_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b1, 8'd10, 4'd0);
    step();
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    checkOutput("abort_result", 32'(result), 32'd3);
    applyStimulus(1'b0, 1'b0, 8'd10, 4'd0);
    step();
    checkOutput("abort_no_done", 32'(done), 32'd0);
    checkOutput("abort_freeze", 32'(result), 32'd3);
    runJob("after_abort_n3", 8'd3, 4'd0, 3, 16'd3, 1'b0);

    // Start and abort together in IDLE: start wins.
    applyStimulus(1'b1, 1'b1, 8'd2, 4'd0);
    step();
    checkOutput("start_abort_busy", 32'(busy), 32'd1);
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd0);
    waitDone(edges, busyCnt, seen);
    checkOutput("start_abort_seen", 32'(seen), 32'd1);
    checkOutput("start_abort_latency", 32'(edges), 32'd2);
    checkOutput("start_abort_result", 32'(result), 32'd1);
    step();

    // Start re-asserted and max_value changed mid-job: N=6,S=1 -> 15*2.
    applyStimulus(1'b1, 1'b0, 8'd6, 4'd1);
    step();
    applyStimulus(1'b1, 1'b0, 8'd2, 4'd1);
    step(); step();
    applyStimulus(1'b0, 1'b0, 8'd2, 4'd1);
    waitDone(edges, busyCnt, seen);
    checkOutput("midjob_seen", 32'(seen), 32'd1);
    checkOutput("midjob_latency", 32'(edges + 2), 32'd7);
    checkOutput("midjob_result", 32'(result), 32'd30);
    checkOutput("midjob_overflow", 32'(overflow), 32'd0);
    applyStimulus(1'b1, 1'b0, 8'd4, 4'd0);
    step();
    checkOutput("done_start_busy", 32'(busy), 32'd0);
    checkOutput("done_start_done", 32'(done), 32'd0);
    checkOutput("done_start_result", 32'(result), 32'd30);
    applyStimulus(1'b0, 1'b0, 8'd4, 4'd0);
    step();
    checkOutput("done_start_idle", 32'(busy), 32'd0);
    checkOutput("done_start_hold", 32'(result), 32'd30);

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule

// File: doc/accum_sequencer.md
Name: accum_sequencer

Overview:
Controller plus datapath that runs a two-phase arithmetic job. Phase 1 is an accumulate, summing a running index into a result register. Phase 2 is an optional power-of-two scale by repeated left shift. The block uses a start/busy/done handshake, supports abort, and keeps a sticky overflow flag. It sits beside the clocked accumulator logic in the element library as the sequenced, well-formed replacement for ad-hoc start/count control.

Parameters:
WIDTH, 16, result width in bits
COUNT_W, 8, width of accumulate length and internal index

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
start  input  1  job request; sampled only in IDLE
abort  input  1  terminate running job; honoured in ACCUM/SCALE only
max_value  input  COUNT_W  accumulate length N; latched on accepted start
shift_count  input  4  number of x2 scale steps S; latched on accepted start
busy  output  1  high while in ACCUM or SCALE
done  output  1  one-cycle pulse in DONE state
result  output  WIDTH  accumulated/scaled value
overflow  output  1  sticky; set on any carry-out or shifted-out 1 during current job

Behaviour:
- Reset (reset==0 at edge): state=IDLE, result=0, overflow=0, busy=0, done=0, index=0, latched N/S=0. Reset overrides start/abort and aborts any job mid-operation.
- States: IDLE, ACCUM, SCALE, DONE. busy/done are decoded from state (Moore outputs).
- IDLE, start=1 (accepting edge E0):
  - Latch N, S.
  - Clear result, overflow and index.
  - Next state: ACCUM if N!=0; else SCALE if S!=0; else DONE.
- IDLE, start=0: hold all outputs.
- ACCUM, one step per edge:
  - result <= result + index, modulo 2^WIDTH, with index zero-extended.
  - overflow |= carry-out.
  - index++.
  - On the step where index==N-1: go to SCALE if S!=0, else DONE.
  - Exactly N adds; final sum = N(N-1)/2 mod 2^WIDTH.
- SCALE, one step per edge:
  - result <= result<<1.
  - overflow |= old result[WIDTH-1].
  - Remaining-steps counter decrements; after S steps go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Latency: done is high in the cycle after edge E(N+S). Minimum is the cycle directly after E0 when N=S=0.
- Result persistence: result and overflow hold after DONE until the next accepted start.
- start outside IDLE: ignored, with no queuing. start in the DONE cycle is also ignored.
- abort=1 in ACCUM/SCALE: next state IDLE. result and overflow freeze at their pre-edge values (no step performed on that edge). done is not pulsed.
- abort in IDLE/DONE: no effect. If start and abort are both high in IDLE, start wins.
- Input changes: max_value/shift_count changes during a job have no effect.
- Widths: index is COUNT_W bits and N-1 ≤ 2^COUNT_W-2, so no index wrap. Adder is WIDTH+1 bits for carry detection.

Decomposition:
- Package accum_seq_pkg holds:
  - state enum (IDLE, ACCUM, SCALE, DONE)
  - default WIDTH/COUNT_W constants
  - localparam for shift_count width (4)
- One natural sub-module: accum_step_dp. It is the datapath register with add-index and shift-left operations, selected by a 2-bit op (HOLD/CLEAR/ADD/SHL), and owns overflow accumulation.
- accum_sequencer holds the FSM, index and shift counters, latches, and outputs.

Test Plan:
- Reset with start held high: result=0, overflow=0, busy=0, done=0; FSM stays IDLE until reset=1 and a start edge arrives.
- N=5, S=0 → busy high 5 cycles; done pulses in the cycle after E5; result=10; overflow=0.
- N=255, S=1 → result=0xFD02, overflow=0, done after E256. Repeat with S=2 → result=0xFA04, overflow=1.
- N=0, S=0 → done in the cycle directly after E0, busy never high, result=0. N=0, S=3 → result stays 0, done after E3.
- N=10, abort at the 4th ACCUM cycle (result=3 before the edge) → IDLE next cycle, result=3, no done pulse. A following start with N=3 gives result=3 with overflow cleared.
- Start pulsed during ACCUM and during the DONE cycle → ignored. max_value changed mid-job → no effect; only the original job completes with its original result.
